game_screen_ctrl: RTL and testbench
===================================

GAME_SCREEN_CTRL -- requirements
Module: game_screen_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
- CLOCK_50  in  1  system clock (50 MHz); the only clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-002 Parameters (name, default, meaning):
- ROWS, 16, display grid rows.
- COLS, 16, display grid columns.
- START_KEY, 32'h20DF_22DD, IR word that starts or restarts the game.
- PAUSE_KEY, 32'h20DF_5AA5, IR word that toggles pause.
- POINTS, 5, score per unit of length.
REQ-003 Ports (name, direction, width, meaning):
- word  in  32  last decoded IR word.
- word_valid  in  1  one-cycle pulse when word is new.
- game_over  in  1  level from the game engine.
- length  in  8  current snake length.
- live_grid  in  ROWS*COLS  game frame.
- start_grid  in  ROWS*COLS  title pattern.
- end_grid  in  ROWS*COLS  end pattern.
- disp_grid  out  ROWS*COLS  registered frame to the matrix driver.
- state  out  2  0=START, 1=PLAY, 2=PAUSE, 3=OVER.
- game_run  out  1  high only in PLAY; gates the game tick.
- game_rst_n  out  1  active-low restart pulse to the game engine.
- score_bcd  out  16  4-digit BCD score.
- hiscore_bcd  out  16  4-digit BCD high score.

Function
REQ-004 Keys SHALL be accepted only in cycles where word_valid=1. A word held constant SHALL NOT retrigger a transition.
REQ-005 START SHALL go to PLAY on START_KEY. In the same cycle, game_rst_n SHALL be low for exactly 1 cycle.
REQ-006 PLAY SHALL go to OVER when game_over=1, and SHALL go to PAUSE on PAUSE_KEY.
REQ-007 If game_over and PAUSE_KEY occur in the same cycle, game_over SHALL win and the next state SHALL be OVER.
REQ-008 PAUSE SHALL return to PLAY on PAUSE_KEY or START_KEY, with no restart pulse. game_over SHALL be ignored while in PAUSE.
REQ-009 OVER SHALL go to START on START_KEY.
REQ-010 Any other key, in any state, SHALL cause no change.
REQ-011 disp_grid SHALL be registered with 1-cycle latency, selected by state:
- START: start_grid.
- PLAY: live_grid.
- PAUSE: holds the last PLAY frame.
- OVER: end_grid.
REQ-012 The binary score SHALL be length*POINTS, computed at 16 bits and saturated to 9999.
REQ-013 A sequential shift-add-3 converter SHALL produce score_bcd.
- It SHALL sample the binary score every cycle while idle, and start when the sample differs from the last converted value.
- It SHALL run 16 iterations.
- score_bcd SHALL update atomically exactly 17 cycles after the start sample.
REQ-014 A change in the binary score during a conversion SHALL NOT abort it. The new value SHALL be converted on the first idle cycle after completion.
REQ-015 score_bcd SHALL hold its value in every state until a conversion completes.

Reset
REQ-016 While reset_n=0, all registers SHALL clear asynchronously:
- state=START, disp_grid=0, game_run=0, game_rst_n=0, score_bcd=0, hiscore_bcd=0, converter idle.
REQ-017 game_rst_n SHALL go high on the first clock after reset_n rises.
REQ-018 Reset asserted during a conversion SHALL discard that conversion.

Configuration
REQ-019 The macro SCREEN_HISCORE_EN SHALL control the high-score feature.
- Defined: on the PLAY->OVER transition, hiscore_bcd SHALL load score_bcd if score_bcd > hiscore_bcd, compared as an unsigned BCD magnitude. It SHALL persist across games and clear only on reset.
- Not defined: hiscore_bcd SHALL be constant 0 and no high-score register SHALL be synthesised.

Verification
REQ-020 Reset, then word=START_KEY with word_valid held for 1 cycle -> state=1, game_rst_n low for 1 cycle, game_run=1; word held with word_valid=0 for 100 cycles -> no further change.
REQ-021 In PLAY, length 3->4 with POINTS=5 -> score_bcd=16'h0020 exactly 17 cycles later; length=255 -> 16'h1275.
REQ-022 In PLAY, game_over=1 and PAUSE_KEY pulse in the same cycle -> state=3, disp_grid=end_grid 1 cycle later.
REQ-023 PAUSE_KEY in PLAY -> state=2, disp_grid frozen while live_grid toggles; PAUSE_KEY again -> state=1 with no game_rst_n pulse.
REQ-024 With SCREEN_HISCORE_EN: end a game at score 0035, then another at 0020 -> hiscore_bcd=16'h0035; without the macro -> hiscore_bcd=0.
REQ-025 Assert reset_n=0 for 2 cycles mid-conversion, 5 cycles after a length change -> all outputs take reset values at once and score_bcd stays 0.

Source files
------------

// File: rtl/game_screen_ctrl.sv
// Screen/game-flow controller: IR-key driven START/PLAY/PAUSE/OVER sequencing,
// registered frame select and a sequential BCD score converter. SCREEN_HISCORE_EN enables the high score.
module game_screen_ctrl #(
    parameter int          ROWS      = 16,
    parameter int          COLS      = 16,
    parameter logic [31:0] START_KEY = 32'h20DF_22DD,
    parameter logic [31:0] PAUSE_KEY = 32'h20DF_5AA5,
    parameter int          POINTS    = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [31:0]          word,
    input  logic                 word_valid,
    input  logic                 game_over,
    input  logic [7:0]           length,
    input  logic [ROWS*COLS-1:0] live_grid,
    input  logic [ROWS*COLS-1:0] start_grid,
    input  logic [ROWS*COLS-1:0] end_grid,
    output logic [ROWS*COLS-1:0] disp_grid,
    output logic [1:0]           state,
    output logic                 game_run,
    output logic                 game_rst_n,
    output logic [15:0]          score_bcd,
    output logic [15:0]          hiscore_bcd
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } screen_t;

    screen_t cur_state;
    screen_t next_state;

    logic start_hit;
    logic pause_hit;

    assign start_hit = word_valid && (word == START_KEY);
    assign pause_hit = word_valid && (word == PAUSE_KEY);
    assign state     = cur_state;

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_START: if (start_hit) next_state = ST_PLAY;
            // game_over outranks a simultaneous pause request
            ST_PLAY: begin
                if (game_over)      next_state = ST_OVER;
                else if (pause_hit) next_state = ST_PAUSE;
            end
            ST_PAUSE: if (pause_hit || start_hit) next_state = ST_PLAY;
            ST_OVER:  if (start_hit) next_state = ST_START;
            default:  next_state = ST_START;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= ST_START;
            game_run   <= 1'b0;
            game_rst_n <= 1'b0;
        end else begin
            cur_state  <= next_state;
            game_run   <= (next_state == ST_PLAY);
            game_rst_n <= !((cur_state == ST_START) && (next_state == ST_PLAY));
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            disp_grid <= '0;
        end else begin
            case (cur_state)
                ST_START: disp_grid <= start_grid;
                ST_PLAY:  disp_grid <= live_grid;
                ST_OVER:  disp_grid <= end_grid;
                default:  disp_grid <= disp_grid;
            endcase
        end
    end

    logic [15:0] raw_score;
    logic [15:0] bin_score;

    assign raw_score = 16'(length) * 16'(POINTS);
    assign bin_score = (raw_score > 16'd9999) ? 16'd9999 : raw_score;

    function automatic logic [15:0] bcd_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic        conv_busy;
    logic [4:0]  conv_iter;
    logic [15:0] conv_bin;
    logic [15:0] conv_bcd;
    logic [15:0] last_conv;
    logic [31:0] dd_shift;

    assign dd_shift = {bcd_adjust(conv_bcd), conv_bin} << 1;

    // Double-dabble: one load cycle, 16 shift cycles, then a single-cycle commit
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            conv_busy <= 1'b0;
            conv_iter <= '0;
            conv_bin  <= '0;
            conv_bcd  <= '0;
            last_conv <= '0;
            score_bcd <= '0;
        end else if (!conv_busy) begin
            if (bin_score != last_conv) begin
                conv_busy <= 1'b1;
                conv_iter <= '0;
                conv_bin  <= bin_score;
                conv_bcd  <= '0;
                last_conv <= bin_score;
            end
        end else if (conv_iter == 5'd16) begin
            score_bcd <= conv_bcd;
            conv_busy <= 1'b0;
        end else begin
            conv_bcd  <= dd_shift[31:16];
            conv_bin  <= dd_shift[15:0];
            conv_iter <= conv_iter + 5'd1;
        end
    end

`ifdef SCREEN_HISCORE_EN
    // Packed BCD orders the same as unsigned binary, so a plain compare suffices
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hiscore_bcd <= '0;
        end else if ((cur_state == ST_PLAY) && (next_state == ST_OVER)
                     && (score_bcd > hiscore_bcd)) begin
            hiscore_bcd <= score_bcd;
        end
    end
`else
    assign hiscore_bcd = '0;
`endif

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed self-checking bench for game_screen_ctrl: key flow, frame select, score timing, reset.
module tb_game_screen_ctrl;

    localparam logic [31:0] START_KEY = 32'h20DF_22DD;
    localparam logic [31:0] PAUSE_KEY = 32'h20DF_5AA5;
    localparam logic [31:0] OTHER_KEY = 32'h20DF_0000;

    logic         CLOCK_50 = 1'b0;
    logic         reset_n;
    logic [31:0]  word;
    logic         word_valid;
    logic         game_over;
    logic [7:0]   length;
    logic [255:0] live_grid;
    logic [255:0] start_grid;
    logic [255:0] end_grid;
    logic [255:0] disp_grid;
    logic [1:0]   state;
    logic         game_run;
    logic         game_rst_n;
    logic [15:0]  score_bcd;
    logic [15:0]  hiscore_bcd;

    int checks = 0;
    int errors = 0;
    logic [15:0]  exp_hi;
    logic [255:0] frame_a;

    game_screen_ctrl dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .word       (word),
        .word_valid (word_valid),
        .game_over  (game_over),
        .length     (length),
        .live_grid  (live_grid),
        .start_grid (start_grid),
        .end_grid   (end_grid),
        .disp_grid  (disp_grid),
        .state      (state),
        .game_run   (game_run),
        .game_rst_n (game_rst_n),
        .score_bcd  (score_bcd),
        .hiscore_bcd(hiscore_bcd)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic press(input logic [31:0] key);
        word       = key;
        word_valid = 1'b1;
        tick(1);
        word_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(2);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d want 0", state); end
        checks++; if (disp_grid !== '0) begin errors++; $display("[TB] FAIL rst_disp: got %h want 0", disp_grid); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("[TB] FAIL rst_run: got %b want 0", game_run); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL rst_rstn: got %b want 0", game_rst_n); end
        checks++; if (score_bcd !== 16'h0) begin errors++; $display("[TB] FAIL rst_score: got %h want 0000", score_bcd); end
        checks++; if (hiscore_bcd !== 16'h0) begin errors++; $display("[TB] FAIL rst_hi: got %h want 0000", hiscore_bcd); end
        reset_n = 1'b1;
        tick(1);
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL rel_rstn: got %b want 1", game_rst_n); end
        checks++; if (disp_grid !== start_grid) begin errors++; $display("[TB] FAIL rel_disp: got %h want %h", disp_grid, start_grid); end
    endtask

    task automatic test_start_key;
        logic bad;
        press(START_KEY);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_state: got %0d want 1", state); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL start_pulse: got %b want 0", game_rst_n); end
        checks++; if (game_run !== 1'b1) begin errors++; $display("[TB] FAIL start_run: got %b want 1", game_run); end
        tick(1);
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL pulse_end: got %b want 1", game_rst_n); end
        checks++; if (disp_grid !== live_grid) begin errors++; $display("[TB] FAIL play_disp: got %h want %h", disp_grid, live_grid); end
        bad = 1'b0;
        repeat (100) begin
            tick(1);
            if (state !== 2'd1 || game_rst_n !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL held_word: got retrigger=%b want 0", bad); end
        press(OTHER_KEY);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL other_key: got %0d want 1", state); end
    endtask

    task automatic test_score;
        length = 8'd3;
        tick(20);
        checks++; if (score_bcd !== 16'h0015) begin errors++; $display("[TB] FAIL score_15: got %h want 0015", score_bcd); end
        length = 8'd4;
        tick(17);
        checks++; if (score_bcd !== 16'h0015) begin errors++; $display("[TB] FAIL score_early: got %h want 0015", score_bcd); end
        tick(1);
        checks++; if (score_bcd !== 16'h0020) begin errors++; $display("[TB] FAIL score_20: got %h want 0020", score_bcd); end
        length = 8'd255;
        tick(20);
        checks++; if (score_bcd !== 16'h1275) begin errors++; $display("[TB] FAIL score_1275: got %h want 1275", score_bcd); end
        length = 8'd7;
        tick(5);
        length = 8'd4;
        tick(12);
        checks++; if (score_bcd !== 16'h1275) begin errors++; $display("[TB] FAIL midchg_hold: got %h want 1275", score_bcd); end
        tick(1);
        checks++; if (score_bcd !== 16'h0035) begin errors++; $display("[TB] FAIL midchg_first: got %h want 0035", score_bcd); end
        tick(17);
        checks++; if (score_bcd !== 16'h0035) begin errors++; $display("[TB] FAIL midchg_wait: got %h want 0035", score_bcd); end
        tick(1);
        checks++; if (score_bcd !== 16'h0020) begin errors++; $display("[TB] FAIL midchg_second: got %h want 0020", score_bcd); end
    endtask

    task automatic test_pause;
        frame_a   = {8{32'hC3C3_1111}};
        live_grid = frame_a;
        tick(1);
        press(PAUSE_KEY);
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL pause_state: got %0d want 2", state); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("[TB] FAIL pause_run: got %b want 0", game_run); end
        live_grid = ~frame_a;
        tick(3);
        checks++; if (disp_grid !== frame_a) begin errors++; $display("[TB] FAIL pause_frozen: got %h want %h", disp_grid, frame_a); end
        game_over = 1'b1;
        tick(2);
        game_over = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL pause_gameover: got %0d want 2", state); end
        press(PAUSE_KEY);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL resume_state: got %0d want 1", state); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL resume_nopulse: got %b want 1", game_rst_n); end
        checks++; if (game_run !== 1'b1) begin errors++; $display("[TB] FAIL resume_run: got %b want 1", game_run); end
        tick(1);
        checks++; if (disp_grid !== ~frame_a) begin errors++; $display("[TB] FAIL resume_disp: got %h want %h", disp_grid, ~frame_a); end
        press(PAUSE_KEY);
        press(START_KEY);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL resume_start: got %0d want 1", state); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL resume_start_pulse: got %b want 1", game_rst_n); end
    endtask

    task automatic test_over_priority;
        game_over = 1'b1;
        press(PAUSE_KEY);
        game_over = 1'b0;
`ifdef SCREEN_HISCORE_EN
        exp_hi = 16'h0020;
`else
        exp_hi = 16'h0000;
`endif
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL over_prio: got %0d want 3", state); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("[TB] FAIL over_run: got %b want 0", game_run); end
        checks++; if (hiscore_bcd !== exp_hi) begin errors++; $display("[TB] FAIL over_hi: got %h want %h", hiscore_bcd, exp_hi); end
        tick(1);
        checks++; if (disp_grid !== end_grid) begin errors++; $display("[TB] FAIL over_disp: got %h want %h", disp_grid, end_grid); end
        press(PAUSE_KEY);
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL over_pausekey: got %0d want 3", state); end
        press(START_KEY);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL over_to_start: got %0d want 0", state); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL over_nopulse: got %b want 1", game_rst_n); end
        tick(1);
        checks++; if (disp_grid !== start_grid) begin errors++; $display("[TB] FAIL start_disp: got %h want %h", disp_grid, start_grid); end
    endtask

    task automatic test_hiscore;
        press(START_KEY);
        length = 8'd7;
        tick(20);
        checks++; if (score_bcd !== 16'h0035) begin errors++; $display("[TB] FAIL game1_score: got %h want 0035", score_bcd); end
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
`ifdef SCREEN_HISCORE_EN
        exp_hi = 16'h0035;
`endif
        checks++; if (hiscore_bcd !== exp_hi) begin errors++; $display("[TB] FAIL game1_hi: got %h want %h", hiscore_bcd, exp_hi); end
        press(START_KEY);
        press(START_KEY);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL game2_state: got %0d want 1", state); end
        length = 8'd4;
        tick(20);
        checks++; if (score_bcd !== 16'h0020) begin errors++; $display("[TB] FAIL game2_score: got %h want 0020", score_bcd); end
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        checks++; if (hiscore_bcd !== exp_hi) begin errors++; $display("[TB] FAIL game2_hi: got %h want %h", hiscore_bcd, exp_hi); end
    endtask

    task automatic test_reset_mid;
        length = 8'd9;
        tick(5);
        reset_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL midrst_state: got %0d want 0", state); end
        checks++; if (disp_grid !== '0) begin errors++; $display("[TB] FAIL midrst_disp: got %h want 0", disp_grid); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rstn: got %b want 0", game_rst_n); end
        checks++; if (score_bcd !== 16'h0) begin errors++; $display("[TB] FAIL midrst_score: got %h want 0000", score_bcd); end
        checks++; if (hiscore_bcd !== 16'h0) begin errors++; $display("[TB] FAIL midrst_hi: got %h want 0000", hiscore_bcd); end
        tick(2);
        reset_n = 1'b1;
        tick(17);
        checks++; if (score_bcd !== 16'h0) begin errors++; $display("[TB] FAIL midrst_discard: got %h want 0000", score_bcd); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release: got %b want 1", game_rst_n); end
        tick(1);
        checks++; if (score_bcd !== 16'h0045) begin errors++; $display("[TB] FAIL midrst_reconv: got %h want 0045", score_bcd); end
    endtask

    initial begin
        reset_n    = 1'b0;
        word       = 32'h0;
        word_valid = 1'b0;
        game_over  = 1'b0;
        length     = 8'd0;
        live_grid  = {8{32'h0F0F_3C3C}};
        start_grid = {8{32'hA5A5_0F0F}};
        end_grid   = {8{32'h1234_5678}};
        exp_hi     = 16'h0;
        frame_a    = '0;
        test_reset();
        test_start_key();
        test_score();
        test_pause();
        test_over_priority();
        test_hiscore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
